ex_muldiv_unit: RTL
===================

Name: ex_muldiv_unit

Overview:
- Iterative multiply/divide unit in the EX stage, directly downstream of the ID/EX pipeline register.
- Consumes the registered rs/rt operands and a decoded mul/div opcode, and owns the architectural HI/LO registers.
- Raises busy so the hazard unit stalls MFHI/MFLO and any new mul/div until the result is committed.
- Radix-2 shift-add multiply and restoring divide: one bit per cycle.

Parameters:
- DATA_W, 32, operand and HI/LO width; the iteration count equals DATA_W.
- DIVZ_LO, 32'hFFFFFFFF, value written to LO on divide-by-zero.

Ports:
- clk  input  1  pipeline clock
- reset  input  1  asynchronous reset, active-low: the block is reset while reset==0
- start  input  1  ID/EX holds a mul/div/mthi/mtlo instruction
- Flush  input  1  ID/EX bubble indicator; start is ignored when Flush==1
- op  input  3  000 NONE, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO; 111 is treated as NONE
- rs  input  DATA_W  operand A (dividend / multiplicand / MTHI-MTLO source)
- rt  input  DATA_W  operand B (divisor / multiplier)
- hi  output  DATA_W  architectural HI
- lo  output  DATA_W  architectural LO
- busy  output  1  operation in flight; high in CALC and SIGN
- done  output  1  one-cycle pulse when HI/LO are updated by MULT/MULTU/DIV/DIVU

Behaviour:
- Reset (reset==0, asynchronous): state=IDLE, hi=0, lo=0, busy=0, done=0, counter=0, all datapath regs=0. Reset mid-operation aborts the operation; no HI/LO write.
- Accept condition: accept = start & ~Flush & (state==IDLE).
  - A start arriving while busy is ignored; the hazard unit must prevent it.
  - op NONE/111 accepted in IDLE is a no-op.
- MTHI/MTLO: on the accepting edge, hi<=rs (MTHI) or lo<=rs (MTLO). No busy, no done pulse.
- MULT/MULTU/DIV/DIVU, with start accepted at edge k:
  - IDLE->CALC at edge k. Latch operand magnitudes (signed ops take |x|; unsigned ops pass through), latch sign_q = sA^sB and sign_r = sA (signed ops only), counter=0.
  - CALC: one iteration per edge, counter+1.
    - Multiply: 2*DATA_W-bit product register, shift-add.
    - Divide: restoring shift-subtract, DATA_W-bit remainder plus 1 guard bit.
    - After DATA_W iterations (counter==DATA_W-1 at the edge) -> SIGN.
  - SIGN: one cycle.
    - Multiply: negate the 64-bit product if signed and sign_q; {hi,lo}<=product.
    - Divide: lo<=quotient, negated if sign_q; hi<=remainder, negated if sign_r.
    - done<=1 and state<=IDLE at edge k+DATA_W+1.
  - Latency: busy=1 after edge k through edge k+DATA_W+1, i.e. DATA_W+1 cycles. hi/lo hold old values until edge k+DATA_W+1. done is high for exactly the one cycle after that edge, while busy is already 0.
- Divide-by-zero (rt==0, DIV or DIVU): takes the normal latency; hi<=rs (unmodified dividend), lo<=DIVZ_LO, done pulses.
- Signed overflow, DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0. This falls out of the magnitude arithmetic; no special case.
- hi/lo outputs are the registers themselves; there is no bypass of in-flight results.
- A start accepted in the cycle where done is high is legal and begins a new operation.

Decomposition:
- Shared package (cpu_defs): MULDIV_OP_* opcode constants (3-bit), muldiv state encoding (IDLE=2'b00, CALC=2'b01, SIGN=2'b10).
- One sub-module, muldiv_core: iteration datapath (product/remainder shift registers, add/subtract, counter), driven by load/step strobes from the FSM in ex_muldiv_unit. The top level keeps the FSM, sign correction and HI/LO registers.

Test Plan:
- Reset: hold reset=0 for 3 cycles mid-CALC of a MULT -> hi=lo=0, busy=0, done=0; after release, a new MULTU 3*5 gives lo=15, hi=0.
- MULT rs=0xFFFFFFFE (-2), rt=0x00000003 -> after exactly 33 busy cycles hi=0xFFFFFFFF, lo=0xFFFFFFFA, one done pulse; MULTU of the same operands -> hi=0x00000002, lo=0xFFFFFFFA.
- DIV rs=0xFFFFFFF9 (-7), rt=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); DIVU 100/7 -> lo=14, hi=2.
- DIVU rs=0x1234, rt=0 -> hi=0x1234, lo=0xFFFFFFFF after normal latency; DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- MTHI rs=0xDEADBEEF then MTLO rs=0x0BADF00D on consecutive cycles -> hi/lo update on each accepting edge, busy never asserts; start with Flush=1 -> no change.
- Start MULT, then pulse start with DIVU while busy -> second request ignored, MULT result intact; DIVU issued in the done cycle -> accepted, busy rises next cycle.

Source files
------------

// File: rtl/cpu_defs.sv
// Shared opcode and state definitions for the EX-stage multiply/divide unit.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package cpu_defs;

  // Decoded mul/div opcode presented by ID/EX; 3'b111 decodes as NONE
  localparam logic [2:0] MULDIV_OP_NONE  = 3'b000;
  localparam logic [2:0] MULDIV_OP_MULT  = 3'b001;
  localparam logic [2:0] MULDIV_OP_MULTU = 3'b010;
  localparam logic [2:0] MULDIV_OP_DIV   = 3'b011;
  localparam logic [2:0] MULDIV_OP_DIVU  = 3'b100;
  localparam logic [2:0] MULDIV_OP_MTHI  = 3'b101;
  localparam logic [2:0] MULDIV_OP_MTLO  = 3'b110;

  typedef enum logic [1:0] {
    MD_IDLE = 2'b00,
    MD_CALC = 2'b01,
    MD_SIGN = 2'b10
  } muldiv_state_t;

endpackage

// File: rtl/muldiv_core.sv
// Iteration datapath: radix-2 shift-add multiply / restoring divide on magnitudes.
// Latency: one bit per step strobe; last asserts during the DATA_W-th step.
// Backpressure: none; the controlling FSM owns sequencing through load/step.
module muldiv_core #(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  step,
  input  logic                  is_div,
  input  logic [DATA_W-1:0]     a,
  input  logic [DATA_W-1:0]     b,
  output logic [2*DATA_W-1:0]   prod,
  output logic [DATA_W-1:0]     quot,
  output logic [DATA_W-1:0]     rem,
  output logic                  last
);

  localparam int CNT_W = $clog2(DATA_W);

  logic [CNT_W-1:0]  counter;
  logic              mode_div;
  logic [DATA_W-1:0] opnd;       // multiplicand or divisor
  logic [DATA_W:0]   mul_sum;
  logic [DATA_W:0]   div_shift;  // partial remainder with guard bit
  logic              div_ge;

  assign last = (counter == CNT_W'(DATA_W - 1));

  // Per-step add and trial-subtract terms
  always_comb begin
    mul_sum   = {1'b0, prod[2*DATA_W-1:DATA_W]} + (prod[0] ? {1'b0, opnd} : '0);
    div_shift = {rem, quot[DATA_W-1]};
    div_ge    = (div_shift >= {1'b0, opnd});
  end

  // Load operands, then shift one bit per step; quot holds the dividend as it shifts out
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      counter  <= '0;
      mode_div <= 1'b0;
      opnd     <= '0;
      prod     <= '0;
      quot     <= '0;
      rem      <= '0;
    end else if (load) begin
      counter  <= '0;
      mode_div <= is_div;
      opnd     <= is_div ? b : a;
      prod     <= {{DATA_W{1'b0}}, b};
      quot     <= a;
      rem      <= '0;
    end else if (step) begin
      counter <= counter + 1'b1;
      if (mode_div) begin
        quot <= {quot[DATA_W-2:0], div_ge};
        rem  <= div_ge ? DATA_W'(div_shift - {1'b0, opnd}) : div_shift[DATA_W-1:0];
      end else begin
        prod <= {mul_sum, prod[DATA_W-1:1]};
      end
    end
  end

endmodule

// File: rtl/ex_muldiv_unit.sv
// EX-stage iterative mul/div unit owning HI/LO; MTHI/MTLO write immediately.
// Latency: MULT/MULTU/DIV/DIVU take DATA_W+1 cycles of busy, then a one-cycle done pulse.
// Backpressure: busy stalls the hazard unit; starts arriving while busy are dropped.
module ex_muldiv_unit
  import cpu_defs::*;
#(
  parameter int                DATA_W  = 32,
  parameter logic [DATA_W-1:0] DIVZ_LO = 32'hFFFFFFFF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              Flush,
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] rs,
  input  logic [DATA_W-1:0] rt,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo,
  output logic              busy,
  output logic              done
);

  muldiv_state_t       state;
  logic                accept, is_mul, is_div, is_signed, load, step, last;
  logic [DATA_W-1:0]   a_mag, b_mag;
  logic [2*DATA_W-1:0] prod;
  logic [DATA_W-1:0]   quot, rem;
  logic                sign_q, sign_r, div_q, divz_q;
  logic [DATA_W-1:0]   dividend_q;  // raw rs, returned in HI on divide-by-zero

  // Opcode decode and operand magnitudes for the core
  always_comb begin
    accept    = start & ~Flush & (state == MD_IDLE);
    is_mul    = (op == MULDIV_OP_MULT) | (op == MULDIV_OP_MULTU);
    is_div    = (op == MULDIV_OP_DIV)  | (op == MULDIV_OP_DIVU);
    is_signed = (op == MULDIV_OP_MULT) | (op == MULDIV_OP_DIV);
    a_mag     = (is_signed & rs[DATA_W-1]) ? -rs : rs;
    b_mag     = (is_signed & rt[DATA_W-1]) ? -rt : rt;
    load      = accept & (is_mul | is_div);
    step      = (state == MD_CALC);
  end

  muldiv_core #(.DATA_W(DATA_W)) u_core (
    .clk    (clk),
    .reset  (reset),
    .load   (load),
    .step   (step),
    .is_div (is_div),
    .a      (a_mag),
    .b      (b_mag),
    .prod   (prod),
    .quot   (quot),
    .rem    (rem),
    .last   (last)
  );

  // Control FSM with sign correction and HI/LO commit
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= MD_IDLE;
      hi         <= '0;
      lo         <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      sign_q     <= 1'b0;
      sign_r     <= 1'b0;
      div_q      <= 1'b0;
      divz_q     <= 1'b0;
      dividend_q <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        MD_IDLE: begin
          if (accept) begin
            if (op == MULDIV_OP_MTHI) begin
              hi <= rs;
            end else if (op == MULDIV_OP_MTLO) begin
              lo <= rs;
            end else if (load) begin
              state      <= MD_CALC;
              busy       <= 1'b1;
              sign_q     <= is_signed & (rs[DATA_W-1] ^ rt[DATA_W-1]);
              sign_r     <= is_signed & rs[DATA_W-1];
              div_q      <= is_div;
              divz_q     <= (rt == '0);
              dividend_q <= rs;
            end
          end
        end
        MD_CALC: begin
          if (last) state <= MD_SIGN;
        end
        MD_SIGN: begin
          if (div_q) begin
            if (divz_q) begin
              hi <= dividend_q;
              lo <= DIVZ_LO;
            end else begin
              lo <= sign_q ? -quot : quot;
              hi <= sign_r ? -rem : rem;
            end
          end else begin
            {hi, lo} <= sign_q ? -prod : prod;
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= MD_IDLE;
        end
        default: state <= MD_IDLE;
      endcase
    end
  end

endmodule
